modport_dut: RTL and testbench

MODPORT_DUT -- requirements
Module: modport_dut

---
 rtl/modport_dut.sv | 83 ++++++++
 tb/tb_modport_dut.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/modport_dut.sv
// Single-clock FIFO with registered occupancy/status flags, a sticky overflow flag and
// one-cycle registered read data.
module modport_dut #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned AF_MARGIN  = 4
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst,
    input  logic                  wr_clk_en,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow_err,
    output logic [ADDR_WIDTH:0]   wr_occupancy,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned PW    = ADDR_WIDTH + 1;

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = PW'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_LEVEL  = PW'(DEPTH - AF_MARGIN);
    localparam logic [ADDR_WIDTH:0] ONE       = PW'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   occ_d;
    logic                  wr_acc;
    logic                  rd_acc;

    always_comb begin
        wr_acc = wr_clk_en && wr_en && !full;
        rd_acc = rd_en && !empty;
        occ_d  = wr_occupancy;
        if (wr_acc && !rd_acc) begin
            occ_d = wr_occupancy + ONE;
        end else if (rd_acc && !wr_acc) begin
            occ_d = wr_occupancy - ONE;
        end
    end

    // Storage is deliberately not reset; stale entries are never reachable by a read.
    always_ff @(posedge wr_clk) begin
        if (wr_acc) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            wr_occupancy <= '0;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            empty        <= 1'b1;
            overflow_err <= 1'b0;
            rd_data      <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (rd_acc) begin
                rd_ptr  <= rd_ptr + ONE;
                rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
            wr_occupancy <= occ_d;
            full         <= (occ_d == DEPTH_CNT);
            almost_full  <= (occ_d >= AF_LEVEL);
            empty        <= (occ_d == '0);
            // A write attempt against a full FIFO latches the error, even if a read frees space.
            if (wr_clk_en && wr_en && full) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_modport_dut.sv
// Self-checking bench for modport_dut: directed scenarios plus randomized traffic, all
// compared against a queue-based reference model.
module tb_modport_dut;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 64;
    localparam int AFM   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b0;
    logic          we = 1'b0;
    logic [DW-1:0] wd = '0;
    logic          re = 1'b0;
    logic          full;
    logic          almost_full;
    logic          overflow_err;
    logic [AW:0]   occ;
    logic [DW-1:0] rd_data;
    logic          empty;

    int unsigned   n_pass  = 0;
    int unsigned   n_total = 0;
    int unsigned   n_fail  = 0;

    logic [DW-1:0] model_q[$];
    logic          model_ovf = 1'b0;
    logic [DW-1:0] model_rd  = '0;

    modport_dut #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .AF_MARGIN (AFM)
    ) dut (
        .wr_clk      (clk),
        .wr_rst      (rst),
        .wr_clk_en   (ce),
        .wr_en       (we),
        .wr_data     (wd),
        .rd_en       (re),
        .full        (full),
        .almost_full (almost_full),
        .overflow_err(overflow_err),
        .wr_occupancy(occ),
        .rd_data     (rd_data),
        .empty       (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = model_q.size();
        check({tag, " occ"}, 64'(occ), 64'(sz));
        check({tag, " full"}, 64'(full), 64'(sz == DEPTH));
        check({tag, " empty"}, 64'(empty), 64'(sz == 0));
        check({tag, " almost_full"}, 64'(almost_full), 64'(sz >= DEPTH - AFM));
        check({tag, " overflow"}, 64'(overflow_err), 64'(model_ovf));
        check({tag, " rd_data"}, 64'(rd_data), 64'(model_rd));
    endtask

    // Starts and ends on a falling edge; outputs are checked half a cycle after the rising edge.
    task automatic step(input logic s_ce, input logic s_we, input logic [DW-1:0] s_wd,
                        input logic s_re, input string tag);
        bit was_full;
        bit was_empty;
        ce = s_ce;
        we = s_we;
        wd = s_wd;
        re = s_re;
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        if (s_ce && s_we && was_full) model_ovf = 1'b1;
        if (s_re && !was_empty) model_rd = model_q.pop_front();
        if (s_ce && s_we && !was_full) model_q.push_back(s_wd);
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    // Reset asserted between clock edges; outputs must clear before the next rising edge.
    task automatic async_reset(input string tag);
        ce = 1'b0;
        we = 1'b0;
        re = 1'b0;
        #2 rst = 1'b1;
        model_q.delete();
        model_ovf = 1'b0;
        model_rd  = '0;
        #1 check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic random_phase(input int cycles, input int wr_pct, input int rd_pct);
        for (int i = 0; i < cycles; i++) begin
            step(($urandom_range(99) < 90), ($urandom_range(99) < wr_pct), $urandom,
                 ($urandom_range(99) < rd_pct), "random");
        end
    endtask

    initial begin
        @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        // Fill 0..63: almost_full at 60, full at 64.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, DW'(i), 1'b0, "fill");
        step(1'b1, 1'b1, 32'hdead_beef, 1'b0, "overflow_write");
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b0, '0, 1'b1, "drain");
            check("drain_order", 64'(rd_data), 64'(i));
        end
        step(1'b0, 1'b0, '0, 1'b1, "read_empty");

        async_reset("reset_clears_ovf");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, $urandom, 1'b0, "ce_low_empty");

        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, $urandom, 1'b0, "refill");
        step(1'b0, 1'b1, $urandom, 1'b0, "ce_low_full");
        step(1'b1, 1'b1, 32'h1234_5678, 1'b1, "full_write_and_read");
        step(1'b0, 1'b0, '0, 1'b1, "after_drop_read");

        async_reset("reset_mid");
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, $urandom, 1'b0, "prefill10");
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, $urandom, 1'b1, "rw_steady");

        async_reset("reset_pre_random");
        random_phase(400, 80, 30);
        random_phase(400, 30, 80);
        random_phase(600, 55, 50);

        async_reset("reset_pre_occ30");
        for (int i = 0; i < 30; i++) step(1'b1, 1'b1, $urandom, 1'b0, "fill30");
        async_reset("reset_at_occ30");
        step(1'b1, 1'b1, 32'hcafe_f00d, 1'b0, "post_reset_write");
        step(1'b0, 1'b0, '0, 1'b1, "post_reset_read");
        check("post_reset_data", 64'(rd_data), 64'h0000_0000_cafe_f00d);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
